// File: rtl/edge_det_multi_if.sv
// Bus interface for edge_det_multi: channel inputs, per-channel mode and
// clear strobes in one direction; pulses, levels, sticky flags and the
// shared event counter in the other.
interface edge_det_multi_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]   d;
    logic [2*WIDTH-1:0] mode;
    logic [WIDTH-1:0]   clr;
    logic               cnt_clr;
    logic [WIDTH-1:0]   pulse;
    logic [WIDTH-1:0]   level;
    logic [WIDTH-1:0]   flag;
    logic [CNT_W-1:0]   evt_cnt;

    modport master (
        output d, mode, clr, cnt_clr,
        input  pulse, level, flag, evt_cnt
    );

    modport slave (
        input  d, mode, clr, cnt_clr,
        output pulse, level, flag, evt_cnt
    );
endinterface

// File: rtl/edge_det_multi.sv
// edge_det_multi: multi-channel edge detector.
// Each channel: input synchroniser -> accepted level -> edge detect with a
// run-time mode (off/rise/fall/both), a registered 1-cycle pulse and a sticky
// flag. A shared saturating counter totals every detected edge.
// Optional feature macro: EDGE_DEBOUNCE_EN inserts a per-channel stability
// filter of DEB_CYCLES cycles between the synchroniser and the accepted level.
// A warm-up counter suppresses detection for SYNC_STAGES+1 cycles after reset
// so that inputs already asserted at reset exit do not fire.
module edge_det_multi #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 4
) (
    input logic             clk,
    input logic             rst,
    edge_det_multi_if.slave bus
);

    localparam int               WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W:0]    CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

    // Elaboration-time parameter sanity
    if (WIDTH < 1) begin : g_chk_width
        $error("edge_det_multi: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("edge_det_multi: SYNC_STAGES must be >= 2");
    end
    if (CNT_W < $clog2(WIDTH + 1)) begin : g_chk_cnt
        $error("edge_det_multi: CNT_W too small for WIDTH");
    end
    if (DEB_CYCLES < 1) begin : g_chk_deb
        $error("edge_det_multi: DEB_CYCLES must be >= 1");
    end

    // Number of set bits, widened so the counter sum cannot overflow.
    function automatic logic [CNT_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{CNT_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  sync_out_s;
    logic [WIDTH-1:0]  acc_s;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [WIDTH-1:0]  pulse_q, pulse_d;
    logic [WIDTH-1:0]  flag_q, flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  rise_s, fall_s, raw_hit_s, hit_s;
    logic [CNT_W-1:0]  cnt_base_s;
    logic [CNT_W:0]    cnt_sum_s;

    // Synchroniser chain: first flop samples the asynchronous inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.d;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out_s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [DEB_W-1:0] deb_q [WIDTH];
    logic [DEB_W-1:0] deb_d [WIDTH];

    // Stability filter: accept a new level after DEB_CYCLES consecutive mismatches
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < WIDTH; i++) begin
            deb_d[i] = '0;
            if (sync_out_s[i] != acc_q[i]) begin
                if (deb_q[i] == DEB_LAST) begin
                    acc_d[i] = sync_out_s[i];
                    deb_d[i] = '0;
                end else begin
                    deb_d[i] = deb_q[i] + DEB_W'(1);
                end
            end else begin
                deb_d[i] = '0;
            end
        end
    end

    // Stability filter state
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            for (int i = 0; i < WIDTH; i++) begin
                deb_q[i] <= deb_d[i];
            end
        end
    end

    assign acc_s = acc_q;
`else
    assign acc_s = sync_out_s;
`endif

    // Edge detection, per-channel mode masking and warm-up suppression
    always_comb begin
        rise_s    = acc_s & ~prev_q;
        fall_s    = ~acc_s & prev_q;
        raw_hit_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            raw_hit_s[i] = (bus.mode[2*i] & rise_s[i]) | (bus.mode[2*i+1] & fall_s[i]);
        end
        if (warm_q != '0) begin
            hit_s = '0;
        end else begin
            hit_s = raw_hit_s;
        end
    end

    // Next state: pulse, sticky flags (set beats clear), saturating counter
    always_comb begin
        prev_d  = acc_s;
        pulse_d = hit_s;
        flag_d  = (flag_q & ~bus.clr) | hit_s;
        if (warm_q != '0) begin
            warm_d = warm_q - WARM_W'(1);
        end else begin
            warm_d = warm_q;
        end
        if (bus.cnt_clr) begin
            cnt_base_s = '0;
        end else begin
            cnt_base_s = cnt_q;
        end
        cnt_sum_s = {1'b0, cnt_base_s} + popcount(hit_s);
        if (cnt_sum_s > CNT_MAX) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Detector state registers; reset drops any pulse in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            warm_q  <= WARM_INIT;
            pulse_q <= '0;
            flag_q  <= '0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            warm_q  <= warm_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pulse   = pulse_q;
    assign bus.level   = acc_s;
    assign bus.flag    = flag_q;
    assign bus.evt_cnt = cnt_q;

endmodule

// File: tb/tb_edge_det_multi.sv
// Directed self-checking bench for edge_det_multi (WIDTH=4, SYNC_STAGES=2,
// CNT_W=8, DEB_CYCLES=4). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, i.e. just after each edge.
module tb_edge_det_multi;

`ifdef EDGE_DEBOUNCE_EN
    localparam int         LAT   = 6;
    localparam int         HOLD  = 5;
    localparam logic [3:0] RST_D = 4'b0000;
`else
    localparam int         LAT   = 2;
    localparam int         HOLD  = 2;
    localparam logic [3:0] RST_D = 4'b0001;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    edge_det_multi_if #(.WIDTH(4), .CNT_W(8)) bus ();

    edge_det_multi #(
        .WIDTH(4), .SYNC_STAGES(2), .CNT_W(8), .DEB_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_level;
        rst = 1'b1;
        bus.d = RST_D; bus.mode = 8'hFF; bus.clr = 4'b0000; bus.cnt_clr = 1'b0;
        tick(); tick();
        checks++;
        if (bus.pulse !== 4'b0000 || bus.flag !== 4'b0000 || bus.level !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: pulse=%b flag=%b level=%b, required all 0000", bus.pulse, bus.flag, bus.level);
        end
        checks++;
        if (bus.evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d required 0", bus.evt_cnt);
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_level = (k >= 2) ? RST_D : 4'b0000;
            checks++;
            if (bus.level !== exp_level || bus.pulse !== 4'b0000) begin
                errors++;
                $display("FAIL reset_exit cyc %0d: level=%b pulse=%b, required level=%b pulse=0000", k, bus.level, bus.pulse, exp_level);
            end
        end
        checks++;
        if (bus.flag !== 4'b0000 || bus.evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_exit_sticky: flag=%b cnt=%0d, required 0000/0", bus.flag, bus.evt_cnt);
        end
    endtask

    task automatic test_mode_off();
        bus.mode = 8'h00;
        bus.d = 4'b1110;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            checks++;
            if (bus.pulse !== 4'b0000) begin
                errors++;
                $display("FAIL mode_off_pulse cyc %0d: got %b required 0000", k, bus.pulse);
            end
        end
        checks++;
        if (bus.level !== 4'b1110 || bus.evt_cnt !== 8'd0 || bus.flag !== 4'b0000) begin
            errors++;
            $display("FAIL mode_off_state: level=%b cnt=%0d flag=%b, required 1110/0/0000", bus.level, bus.evt_cnt, bus.flag);
        end
        bus.d = 4'b0000;
        for (int k = 1; k <= LAT + 3; k++) tick();
        checks++;
        if (bus.level !== 4'b0000 || bus.evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mode_off_back: level=%b cnt=%0d, required 0000/0", bus.level, bus.evt_cnt);
        end
    endtask

    task automatic test_rise_fall();
        logic [3:0] exp_p;
        bus.mode = 8'hFF;
        bus.d = 4'b0001;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            exp_p = (k == LAT + 1) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.pulse !== exp_p) begin
                errors++;
                $display("FAIL rise_pulse cyc %0d: got %b required %b", k, bus.pulse, exp_p);
            end
        end
        for (int k = LAT + 3; k <= 5; k++) tick();
        checks++;
        if (bus.evt_cnt !== 8'd1 || bus.flag !== 4'b0001) begin
            errors++;
            $display("FAIL rise_state: cnt=%0d flag=%b, required 1/0001", bus.evt_cnt, bus.flag);
        end
        bus.d = 4'b0000;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            exp_p = (k == LAT + 1) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.pulse !== exp_p) begin
                errors++;
                $display("FAIL fall_pulse cyc %0d: got %b required %b", k, bus.pulse, exp_p);
            end
        end
        checks++;
        if (bus.evt_cnt !== 8'd2 || bus.flag !== 4'b0001) begin
            errors++;
            $display("FAIL fall_state: cnt=%0d flag=%b, required 2/0001", bus.evt_cnt, bus.flag);
        end
    endtask

    task automatic test_multi_channel();
        logic [3:0] exp_p;
        bus.clr = 4'b1111;
        tick();
        bus.clr = 4'b0000;
        checks++;
        if (bus.flag !== 4'b0000) begin
            errors++;
            $display("FAIL multi_clr: flag=%b required 0000", bus.flag);
        end
        bus.mode = 8'h24;
        bus.d = 4'b0100;
        for (int k = 1; k <= LAT + 3; k++) tick();
        checks++;
        if (bus.evt_cnt !== 8'd2 || bus.flag !== 4'b0000) begin
            errors++;
            $display("FAIL multi_masked_rise: cnt=%0d flag=%b, required 2/0000", bus.evt_cnt, bus.flag);
        end
        bus.d = 4'b0010;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            exp_p = (k == LAT + 1) ? 4'b0110 : 4'b0000;
            checks++;
            if (bus.pulse !== exp_p) begin
                errors++;
                $display("FAIL multi_pulse cyc %0d: got %b required %b", k, bus.pulse, exp_p);
            end
        end
        checks++;
        if (bus.evt_cnt !== 8'd4 || bus.flag !== 4'b0110) begin
            errors++;
            $display("FAIL multi_state: cnt=%0d flag=%b, required 4/0110", bus.evt_cnt, bus.flag);
        end
    endtask

    task automatic test_clr_collision();
        bus.clr = 4'b1111;
        tick();
        bus.clr = 4'b0000;
        bus.mode = 8'h03;
        bus.d = 4'b0011;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            checks++;
            if (bus.pulse !== 4'b0000) begin
                errors++;
                $display("FAIL clr_pre_pulse cyc %0d: got %b required 0000", k, bus.pulse);
            end
        end
        bus.clr = 4'b0001;
        tick();
        checks++;
        if (bus.pulse !== 4'b0001 || bus.flag !== 4'b0001) begin
            errors++;
            $display("FAIL clr_set_wins: pulse=%b flag=%b, required 0001/0001", bus.pulse, bus.flag);
        end
        tick();
        bus.clr = 4'b0000;
        checks++;
        if (bus.flag !== 4'b0000 || bus.evt_cnt !== 8'd5) begin
            errors++;
            $display("FAIL clr_alone: flag=%b cnt=%0d, required 0000/5", bus.flag, bus.evt_cnt);
        end
    endtask

    task automatic test_saturation();
        bus.mode = 8'hFF;
        for (int t = 0; t < 10; t++) begin
            bus.d = ~bus.d;
            for (int h = 0; h < HOLD; h++) tick();
        end
        for (int k = 0; k < LAT + 2; k++) tick();
        checks++;
        if (bus.evt_cnt !== 8'd45) begin
            errors++;
            $display("FAIL sat_partial: cnt=%0d required 45", bus.evt_cnt);
        end
        for (int t = 0; t < 60; t++) begin
            bus.d = ~bus.d;
            for (int h = 0; h < HOLD; h++) tick();
        end
        for (int k = 0; k < LAT + 2; k++) tick();
        checks++;
        if (bus.evt_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_top: cnt=%0d required 255", bus.evt_cnt);
        end
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        checks++;
        if (bus.evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sat_cnt_clr: cnt=%0d required 0", bus.evt_cnt);
        end
        bus.d = ~bus.d;
        for (int k = 0; k < LAT; k++) tick();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        checks++;
        if (bus.pulse !== 4'b1111 || bus.evt_cnt !== 8'd4) begin
            errors++;
            $display("FAIL clr_then_add: pulse=%b cnt=%0d, required 1111/4", bus.pulse, bus.evt_cnt);
        end
    endtask

    task automatic test_mid_reset();
        bus.mode = 8'hFF;
        bus.d = 4'b0000;
        for (int k = 0; k < LAT; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.pulse !== 4'b0000 || bus.evt_cnt !== 8'd0 || bus.flag !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_state: pulse=%b cnt=%0d flag=%b, required 0000/0/0000", bus.pulse, bus.evt_cnt, bus.flag);
        end
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            checks++;
            if (bus.pulse !== 4'b0000 || bus.level !== 4'b0000) begin
                errors++;
                $display("FAIL mid_reset_after cyc %0d: pulse=%b level=%b, required 0000/0000", k, bus.pulse, bus.level);
            end
        end
    endtask

`ifdef EDGE_DEBOUNCE_EN
    task automatic test_debounce();
        logic [3:0] exp_p;
        bus.mode = 8'hFF;
        bus.d = 4'b1000;
        tick(); tick();
        bus.d = 4'b0000;
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++;
            if (bus.pulse !== 4'b0000) begin
                errors++;
                $display("FAIL deb_glitch cyc %0d: got %b required 0000", k, bus.pulse);
            end
        end
        bus.d = 4'b1000;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            exp_p = (k == LAT + 1) ? 4'b1000 : 4'b0000;
            checks++;
            if (bus.pulse !== exp_p) begin
                errors++;
                $display("FAIL deb_stable cyc %0d: got %b required %b", k, bus.pulse, exp_p);
            end
        end
        bus.d = 4'b0000;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (bus.pulse !== 4'b0000 || bus.evt_cnt !== 8'd0) begin
                errors++;
                $display("FAIL deb_mid_reset cyc %0d: pulse=%b cnt=%0d, required 0000/0", k, bus.pulse, bus.evt_cnt);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mode_off();
        test_rise_fall();
        test_multi_channel();
        test_clr_collision();
        test_saturation();
        test_mid_reset();
`ifdef EDGE_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
